// File: rtl/sy_pkg.sv
// Shared pipeline definitions: default datapath width, the regfile index type
// and the flop macros that every sequential element in the pipeline uses.
`ifndef SY_DFF_MACROS
`define SY_DFF_MACROS
`define TCQ
// NOTE: flops always use non-blocking assignment so that every register samples pre-edge values.
`define DFF_CR(q, d, clk, rst, rv) always_ff @(posedge clk or posedge rst) if (rst) q <= `TCQ rv; else q <= `TCQ d;
`define DFF_IS_R(q, d, clk, rst, sv) always_ff @(posedge clk or posedge rst) if (rst) q <= `TCQ sv; else q <= `TCQ d;
`endif

package sy_pkg;
    localparam int DWTH = 32;
    typedef logic [4:0] rf_idx_t;
endpackage

// File: rtl/sy_ppl_scoreboard.sv
// Busy-bit scoreboard: marks issued destinations, clears them on write-back or
// flush, and publishes a registered count of outstanding destinations.
module sy_ppl_scoreboard
    import sy_pkg::*;
#(
    parameter int NR_REG   = 32,
    parameter int ZERO_REG = 1,
    localparam int IDX_W   = $clog2(NR_REG)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              iss_en_i,
    input  logic [IDX_W-1:0]  iss_idx_i,
    input  logic              flush_i,
    input  logic [NR_REG-1:0] wr_hit_i,
    output logic [NR_REG-1:0] busy_o,
    output logic [IDX_W:0]    busy_cnt_o
);

    logic [NR_REG-1:0] busy_q, busy_d;
    logic [IDX_W:0]    cnt_q, cnt_d;

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        busy_d = busy_q & ~wr_hit_i;
        if (flush_i) begin
            busy_d = '0;
        end else if (iss_en_i && !(ZERO_REG != 0 && iss_idx_i == '0)) begin
            // A new producer outlives a same-cycle write-back of the old one.
            busy_d[iss_idx_i] = 1'b1;
        end
        cnt_d = '0;
        for (int i = 0; i < NR_REG; i++) begin
            cnt_d = cnt_d + {{IDX_W{1'b0}}, busy_d[i]};
        end
    end

    `DFF_CR(busy_q, busy_d, clk_i, rst_i, '0)
    `DFF_CR(cnt_q, cnt_d, clk_i, rst_i, '0)

    assign busy_o     = busy_q;
    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/sy_ppl_regfile_sb.sv
// Pipeline register file with prioritised multi-port write-back, same-cycle
// read bypass and an attached busy scoreboard for hazard detection.
module sy_ppl_regfile_sb
    import sy_pkg::*;
#(
    parameter int NR_RD    = 2,
    parameter int NR_WR    = 2,
    parameter int NR_REG   = 32,
    parameter int DATA_W   = DWTH,
    parameter int ZERO_REG = 1,
    localparam int IDX_W   = $clog2(NR_REG)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NR_RD-1:0][IDX_W-1:0] rd_idx_i,
    output logic [NR_RD-1:0][DATA_W-1:0] rd_data_o,
    output logic [NR_RD-1:0]            rd_busy_o,
    input  logic                        iss_en_i,
    input  logic [IDX_W-1:0]            iss_idx_i,
    input  logic [NR_WR-1:0]            wb_en_i,
    input  logic [NR_WR-1:0][IDX_W-1:0] wb_idx_i,
    input  logic [NR_WR-1:0][DATA_W-1:0] wb_data_i,
    input  logic                        flush_i,
    output logic [IDX_W:0]              busy_cnt_o
);

    logic [NR_REG-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NR_WR-1:0]              wb_ok;
    logic [NR_REG-1:0]             wr_hit;
    logic [NR_REG-1:0]             busy;

    always_comb begin
        regs_d = regs_q;
        wr_hit = '0;
        for (int k = 0; k < NR_WR; k++) begin
            wb_ok[k] = wb_en_i[k] && !(ZERO_REG != 0 && wb_idx_i[k] == '0);
        end
        // Walk from the lowest priority upward so port 0 lands last and wins.
        for (int k = NR_WR - 1; k >= 0; k--) begin
            if (wb_ok[k]) begin
                regs_d[wb_idx_i[k]] = wb_data_i[k];
                wr_hit[wb_idx_i[k]] = 1'b1;
            end
        end
    end

    // NOTE: the data array is reset too, so a never-written register reads as zero.
    `DFF_CR(regs_q, regs_d, clk_i, rst_i, '0)

    always_comb begin
        for (int j = 0; j < NR_RD; j++) begin
            rd_data_o[j] = regs_q[rd_idx_i[j]];
            if (ZERO_REG != 0 && rd_idx_i[j] == '0) begin
                rd_data_o[j] = '0;
            end
            for (int k = NR_WR - 1; k >= 0; k--) begin
                if (wb_ok[k] && wb_idx_i[k] == rd_idx_i[j]) begin
                    rd_data_o[j] = wb_data_i[k];
                end
            end
            rd_busy_o[j] = busy[rd_idx_i[j]] && !wr_hit[rd_idx_i[j]];
        end
    end

    sy_ppl_scoreboard #(
        .NR_REG   (NR_REG),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .iss_en_i   (iss_en_i),
        .iss_idx_i  (iss_idx_i),
        .flush_i    (flush_i),
        .wr_hit_i   (wr_hit),
        .busy_o     (busy),
        .busy_cnt_o (busy_cnt_o)
    );

endmodule

// File: tb/tb_sy_ppl_regfile_sb.sv
// Bench for sy_ppl_regfile_sb: directed vector table, an asynchronous reset
// sequence, then random traffic against an array-based reference model.
module tb_sy_ppl_regfile_sb;
    import sy_pkg::*;

    localparam int NR_RD = 2, NR_WR = 2, NR_REG = 32, DW = 32, IW = 5;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NR_RD-1:0][IW-1:0] rd_idx;
    logic [NR_RD-1:0][DW-1:0] rd_data;
    logic [NR_RD-1:0]         rd_busy;
    logic                     iss_en;
    logic [IW-1:0]            iss_idx;
    logic [NR_WR-1:0]         wb_en;
    logic [NR_WR-1:0][IW-1:0] wb_idx;
    logic [NR_WR-1:0][DW-1:0] wb_data;
    logic                     flush;
    logic [IW:0]              busy_cnt;

    int checks = 0;
    int errors = 0;

    sy_ppl_regfile_sb #(
        .NR_RD(NR_RD), .NR_WR(NR_WR), .NR_REG(NR_REG), .DATA_W(DW), .ZERO_REG(1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .rd_idx_i(rd_idx), .rd_data_o(rd_data),
        .rd_busy_o(rd_busy), .iss_en_i(iss_en), .iss_idx_i(iss_idx),
        .wb_en_i(wb_en), .wb_idx_i(wb_idx), .wb_data_i(wb_data),
        .flush_i(flush), .busy_cnt_o(busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                     iss_en;
        logic [IW-1:0]            iss_idx;
        logic [NR_WR-1:0]         wb_en;
        logic [NR_WR-1:0][IW-1:0] wb_idx;
        logic [NR_WR-1:0][DW-1:0] wb_data;
        logic                     flush;
        logic [NR_RD-1:0][IW-1:0] rd_idx;
        logic [NR_RD-1:0][DW-1:0] e_data;
        logic [NR_RD-1:0]         e_busy;
        logic [IW:0]              e_cnt;
    } vec_t;

    // Reference state: architectural values and the set of pending destinations.
    logic [DW-1:0] mdl_regs [NR_REG];
    bit            mdl_busy [NR_REG];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ie, input int ii, input logic [1:0] we,
                                input int wi0, input int wd0, input int wi1, input int wd1,
                                input logic fl, input int r0, input int r1,
                                input int ed0, input logic eb0, input int ed1, input logic eb1,
                                input int ec);
        vec_t v;
        v.iss_en = ie;          v.iss_idx = IW'(ii);
        v.wb_en = we;           v.flush = fl;
        v.wb_idx[0] = IW'(wi0); v.wb_data[0] = DW'(wd0);
        v.wb_idx[1] = IW'(wi1); v.wb_data[1] = DW'(wd1);
        v.rd_idx[0] = IW'(r0);  v.rd_idx[1] = IW'(r1);
        v.e_data[0] = DW'(ed0); v.e_busy[0] = eb0;
        v.e_data[1] = DW'(ed1); v.e_busy[1] = eb1;
        v.e_cnt = (IW+1)'(ec);
        return v;
    endfunction

    function automatic logic [DW-1:0] mdl_read(input vec_t v, input int idx);
        if (idx == 0) return '0;
        for (int k = 0; k < NR_WR; k++)
            if (v.wb_en[k] && v.wb_idx[k] != 0 && int'(v.wb_idx[k]) == idx) return v.wb_data[k];
        return mdl_regs[idx];
    endfunction

    function automatic bit mdl_written(input vec_t v, input int idx);
        for (int k = 0; k < NR_WR; k++)
            if (v.wb_en[k] && v.wb_idx[k] != 0 && int'(v.wb_idx[k]) == idx) return 1'b1;
        return 1'b0;
    endfunction

    task automatic mdl_update(input vec_t v);
        logic [DW-1:0] nxt [NR_REG];
        for (int i = 1; i < NR_REG; i++) nxt[i] = mdl_read(v, i);
        for (int i = 1; i < NR_REG; i++) begin
            mdl_regs[i] = nxt[i];
            if (mdl_written(v, i)) mdl_busy[i] = 1'b0;
        end
        if (v.flush) begin
            for (int i = 0; i < NR_REG; i++) mdl_busy[i] = 1'b0;
        end else if (v.iss_en && v.iss_idx != 0) begin
            mdl_busy[v.iss_idx] = 1'b1;
        end
    endtask

    function automatic int mdl_cnt();
        int n = 0;
        foreach (mdl_busy[i]) n += int'(mdl_busy[i]);
        return n;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < NR_REG; i++) begin
            mdl_regs[i] = '0;
            mdl_busy[i] = 1'b0;
        end
    endtask

    // Drives one cycle starting just after a rising edge; returns just after the next.
    task automatic run_cycle(input vec_t v, input bit use_tbl, input string tag);
        logic [DW-1:0] ed;
        logic          eb;
        iss_en = v.iss_en; iss_idx = v.iss_idx; flush = v.flush;
        wb_en = v.wb_en;   wb_idx = v.wb_idx;   wb_data = v.wb_data;
        rd_idx = v.rd_idx;
        @(negedge clk);
        for (int j = 0; j < NR_RD; j++) begin
            ed = use_tbl ? v.e_data[j] : mdl_read(v, int'(v.rd_idx[j]));
            eb = use_tbl ? v.e_busy[j] : (mdl_busy[v.rd_idx[j]] && !mdl_written(v, int'(v.rd_idx[j])));
            check($sformatf("%s rd_data[%0d]", tag, j), rd_data[j], ed);
            check($sformatf("%s rd_busy[%0d]", tag, j), DW'(rd_busy[j]), DW'(eb));
        end
        @(posedge clk);
        #1;
        mdl_update(v);
        check($sformatf("%s busy_cnt", tag), DW'(busy_cnt), use_tbl ? DW'(v.e_cnt) : DW'(mdl_cnt()));
    endtask

    task automatic idle();
        iss_en = 0; iss_idx = '0; flush = 0; wb_en = '0; wb_idx = '0; wb_data = '0;
    endtask

    vec_t tbl [14];
    vec_t v;

    initial begin
        //            ie ii  we    wi0 wd0   wi1 wd1   fl r0 r1 ed0   eb0 ed1   eb1 ec
        tbl[0]  = mk(0, 0,  2'b11, 3, 'hAA, 3, 'hBB, 0, 3, 3, 'hAA, 0, 'hAA, 0, 0);
        tbl[1]  = mk(0, 0,  2'b00, 0, 0,    0, 0,    0, 3, 0, 'hAA, 0, 0,    0, 0);
        tbl[2]  = mk(0, 0,  2'b01, 0, 'h55, 0, 0,    0, 0, 0, 0,    0, 0,    0, 0);
        tbl[3]  = mk(0, 0,  2'b00, 0, 0,    0, 0,    0, 0, 3, 0,    0, 'hAA, 0, 0);
        tbl[4]  = mk(1, 7,  2'b00, 0, 0,    0, 0,    0, 7, 7, 0,    0, 0,    0, 1);
        tbl[5]  = mk(0, 0,  2'b00, 0, 0,    0, 0,    0, 7, 3, 0,    1, 'hAA, 0, 1);
        tbl[6]  = mk(0, 0,  2'b01, 7, 'h12, 0, 0,    0, 7, 7, 'h12, 0, 'h12, 0, 0);
        tbl[7]  = mk(1, 9,  2'b00, 0, 0,    0, 0,    0, 9, 7, 0,    0, 'h12, 0, 1);
        tbl[8]  = mk(1, 9,  2'b10, 0, 0,    9, 'h34, 0, 9, 9, 'h34, 0, 'h34, 0, 1);
        tbl[9]  = mk(0, 0,  2'b00, 0, 0,    0, 0,    0, 9, 7, 'h34, 1, 'h12, 0, 1);
        tbl[10] = mk(1, 4,  2'b00, 0, 0,    0, 0,    1, 4, 9, 0,    0, 'h34, 1, 0);
        tbl[11] = mk(0, 0,  2'b00, 0, 0,    0, 0,    0, 4, 9, 0,    0, 'h34, 0, 0);
        tbl[12] = mk(1, 0,  2'b00, 0, 0,    0, 0,    0, 0, 9, 0,    0, 'h34, 0, 0);
        tbl[13] = mk(1, 5,  2'b01, 5, 'h77, 0, 0,    1, 5, 0, 'h77, 0, 0,    0, 0);

        idle();
        rst = 1'b1;
        rd_idx[0] = 5; rd_idx[1] = 5;
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int j = 0; j < NR_RD; j++) begin
            check($sformatf("reset rd_data[%0d]", j), rd_data[j], '0);
            check($sformatf("reset rd_busy[%0d]", j), DW'(rd_busy[j]), '0);
        end
        check("reset busy_cnt", DW'(busy_cnt), '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int t = 0; t < 14; t++) run_cycle(tbl[t], 1'b1, $sformatf("vec%0d", t));

        // Three pending destinations, then reset lands between clock edges.
        for (int r = 1; r <= 3; r++) begin
            v = mk(1, r, 2'b01, 10 + r, 'hC0 + r, 0, 0, 0, r, 0, 0, 0, 0, 0, 0);
            run_cycle(v, 1'b0, $sformatf("pre_rst%0d", r));
        end
        check("pre_rst busy_cnt is 3", DW'(busy_cnt), 3);
        idle();
        rd_idx[0] = 11; rd_idx[1] = 3;
        #2;
        rst = 1'b1;
        #1;
        check("async rst busy_cnt", DW'(busy_cnt), '0);
        check("async rst rd_data0", rd_data[0], '0);
        check("async rst rd_data1", rd_data[1], '0);
        check("async rst rd_busy", DW'(rd_busy), '0);
        mdl_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int n = 0; n < 400; n++) begin
            v.iss_en  = ($urandom_range(0, 2) == 0);
            v.iss_idx = IW'($urandom_range(0, 15));
            v.wb_en   = NR_WR'($urandom_range(0, 3));
            v.flush   = ($urandom_range(0, 15) == 0);
            for (int k = 0; k < NR_WR; k++) begin
                v.wb_idx[k]  = IW'($urandom_range(0, 15));
                v.wb_data[k] = DW'($urandom);
            end
            for (int j = 0; j < NR_RD; j++) v.rd_idx[j] = IW'($urandom_range(0, 15));
            run_cycle(v, 1'b0, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sy_ppl_regfile_sb.md
SY_PPL_REGFILE_SB -- requirements
Module: sy_ppl_regfile_sb

Interface
REQ-001 SHALL have parameter NR_RD, default 2, number of read ports (1..4).
REQ-002 SHALL have parameter NR_WR, default 2, number of write-back ports (1..4); port 0 highest priority.
REQ-003 SHALL have parameter NR_REG, default 32, number of architectural registers (power of two, 8..64).
REQ-004 SHALL have parameter DATA_W, default DWTH, register data width.
REQ-005 SHALL have parameter ZERO_REG, default 1; 1 = register 0 hard-wired to zero and never busy.
REQ-006 SHALL have derived localparam IDX_W = $clog2(NR_REG).
REQ-007 SHALL have ports, one clock, reset asynchronous active-high:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- rd_idx_i  in  [NR_RD][IDX_W]  read register index
- rd_data_o  out  [NR_RD][DATA_W]  read data, bypassed
- rd_busy_o  out  [NR_RD]  source still awaiting write-back
- iss_en_i  in  1  issue of an instruction with a destination register
- iss_idx_i  in  IDX_W  issued destination index
- wb_en_i  in  [NR_WR]  write-back valid
- wb_idx_i  in  [NR_WR][IDX_W]  write-back index
- wb_data_i  in  [NR_WR][DATA_W]  write-back data
- flush_i  in  1  pipeline flush; discard all pending destinations
- busy_cnt_o  out  IDX_W+1  number of busy registers

Function
REQ-008 SHALL qualify each write port as wb_en_i[k] && !(ZERO_REG && wb_idx_i[k]==0).
REQ-009 SHALL, when several qualified ports target the same index in one cycle, write only the lowest-numbered port's data.
REQ-010 SHALL commit qualified writes on the rising clk_i edge; multiple distinct indices commit in the same cycle.
REQ-011 SHALL drive rd_data_o[j] combinationally: the highest-priority qualified same-cycle write to rd_idx_i[j] if any, else stored value; 0 when ZERO_REG && rd_idx_i[j]==0.
REQ-012 SHALL keep a busy bit per register; iss_en_i sets busy[iss_idx_i] at the next edge (ignored for register 0 when ZERO_REG).
REQ-013 SHALL clear busy[i] at the next edge when any qualified write targets i.
REQ-014 SHALL, on same-cycle issue and write-back to the same index, leave the bit set (new producer wins), while still committing the data.
REQ-015 SHALL drive rd_busy_o[j] = busy[rd_idx_i[j]] && no qualified same-cycle write to that index && !(iss_en_i... not considered); issue in the current cycle does not affect rd_busy_o until the next cycle.
REQ-016 SHALL, on flush_i, clear all busy bits at the next edge; flush_i overrides a simultaneous iss_en_i; register data writes in that cycle still commit.
REQ-017 SHALL register busy_cnt_o as the population count of the busy vector after the update (one-cycle latency to the busy change).
REQ-018 SHALL hold all state when no enable, flush or issue is asserted.

Reset
REQ-019 SHALL, while rst_i is high, asynchronously clear all registers to 0, all busy bits to 0, busy_cnt_o to 0.
REQ-020 SHALL drive rd_data_o to 0 and rd_busy_o to 0 for all ports during reset absent same-cycle writes (writes ignored during reset).
REQ-021 SHALL resume normal operation on the first rising edge after rst_i deasserts; reset mid-operation discards pending writes and busy state.

Structure
REQ-022 SHALL import sy_pkg; DWTH and a regfile index type default belong in sy_pkg; no new package types are required.
REQ-023 SHALL place the busy vector, set/clear/flush logic and popcount in one sub-module sy_ppl_scoreboard; data array, priority write mux and bypass remain in the top.
REQ-024 SHALL use the codebase DFF_CR/DFF_IS_R/TCQ macros for every flop.

Verification
REQ-025 SHALL cover: reset then read idx 5 on all ports -> rd_data_o=0, rd_busy_o=0, busy_cnt_o=0.
REQ-026 SHALL cover: wb0 idx 3 data 0xAA and wb1 idx 3 data 0xBB same cycle -> same-cycle read idx 3 returns 0xAA; next-cycle stored value 0xAA.
REQ-027 SHALL cover: write idx 0 data 0x55 with ZERO_REG=1 -> read idx 0 returns 0, busy_cnt_o unchanged.
REQ-028 SHALL cover: issue idx 7, next cycle rd_busy_o=1, busy_cnt_o=1; wb idx 7 data 0x12 -> that cycle rd_busy_o=0, rd_data_o=0x12; next cycle busy_cnt_o=0.
REQ-029 SHALL cover: busy idx 9; same cycle issue idx 9 and wb idx 9 -> busy stays 1, data updated; then issue idx 4 plus flush_i -> busy_cnt_o=0 next cycle.
REQ-030 SHALL cover: rst_i asserted asynchronously mid-cycle with 3 busy registers -> busy_cnt_o and all data 0 immediately, before the next clock edge.
